coax_tx_framer: RTL



---
 rtl/coax_tx_framer_if.sv | 15 +
 rtl/coax_tx_framer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/coax_tx_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : coax_tx_framer_if
// Function : Word handshake between the transmit FIFO logic and the framer.
// Revision : 1.0
// ============================================================================
interface coax_tx_framer_if;
  logic [9:0] data;
  logic       data_valid;
  logic       data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);
endinterface
`default_nettype wire

// File: rtl/coax_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : coax_tx_framer
// Function : Frames 10-bit words (quiesce, violation, sync/data/parity, end)
//            and half-bit encodes them onto the coax line.
// Revision : 1.0
// ============================================================================
module coax_tx_framer #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  coax_tx_framer_if.slave  bus,
  output logic             tx,
  output logic             tx_active,
  output logic             busy,
  output logic             frame_done
);

  localparam int c_CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int c_HALF  = CLOCKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_VIOLATION,
    ST_SYNC,
    ST_DATA,
    ST_PARITY,
    ST_END
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [c_CNT_W-1:0] r_clk_cnt;
  logic [c_CNT_W-1:0] w_clk_cnt_nx;
  logic [3:0]         r_cell_idx;
  logic [3:0]         w_cell_idx_nx;
  logic [9:0]         r_shift;
  logic [9:0]         w_shift_nx;
  logic               r_parity;
  logic               w_parity_nx;
  logic               r_tx;
  logic               r_tx_active;
  logic               r_frame_done;
  logic               w_cell_end;
  logic               w_ready;
  logic               w_accept;
  logic               w_level_nx;

  function automatic logic [3:0] last_cell_idx(input state_t s);
    case (s)
      ST_QUIESCE:   return 4'd4;
      ST_VIOLATION: return 4'd2;
      ST_DATA:      return 4'd9;
      ST_END:       return 4'd2;
      default:      return 4'd0;
    endcase
  endfunction

  // Line level for a given position; a plain bit b is ~b then b across the cell.
  function automatic logic line_level(
    input state_t             s,
    input logic [3:0]         idx,
    input logic [c_CNT_W-1:0] cnt,
    input logic               data_bit,
    input logic               par_bit
  );
    logic second;
    second = (cnt >= c_CNT_W'(c_HALF));
    case (s)
      ST_QUIESCE,
      ST_SYNC:      return second;
      ST_VIOLATION: return ({idx, second} < 5'd3);
      ST_DATA:      return ~(data_bit ^ second);
      ST_PARITY:    return ~(par_bit ^ second);
      ST_END: begin
        if (idx == 4'd0)      return ~second;
        else if (idx == 4'd1) return 1'b1;
        else                  return 1'b0;
      end
      default:      return 1'b0;
    endcase
  endfunction

  assign w_cell_end     = (r_clk_cnt == c_CNT_W'(CLOCKS_PER_BIT - 1));
  assign w_ready        = reset_n &&
                          ((r_state == ST_IDLE) || ((r_state == ST_PARITY) && w_cell_end));
  assign w_accept       = bus.data_valid && w_ready;
  assign bus.data_ready = w_ready;

  always_comb begin
    w_state_nx    = r_state;
    w_clk_cnt_nx  = r_clk_cnt;
    w_cell_idx_nx = r_cell_idx;
    w_shift_nx    = r_shift;
    w_parity_nx   = r_parity;

    if (r_state == ST_IDLE) begin
      if (w_accept) begin
        w_state_nx    = ST_QUIESCE;
        w_clk_cnt_nx  = '0;
        w_cell_idx_nx = '0;
        w_shift_nx    = bus.data;
        w_parity_nx   = ^{1'b1, bus.data};
      end
    end else begin
      w_clk_cnt_nx = w_cell_end ? '0 : r_clk_cnt + c_CNT_W'(1);
      if (w_cell_end) begin
        if (r_cell_idx != last_cell_idx(r_state)) begin
          w_cell_idx_nx = r_cell_idx + 4'd1;
          if (r_state == ST_DATA) begin
            w_shift_nx = {r_shift[8:0], 1'b0};
          end
        end else begin
          w_cell_idx_nx = '0;
          case (r_state)
            ST_QUIESCE:   w_state_nx = ST_VIOLATION;
            ST_VIOLATION: w_state_nx = ST_SYNC;
            ST_SYNC:      w_state_nx = ST_DATA;
            ST_DATA:      w_state_nx = ST_PARITY;
            ST_PARITY: begin
              // A word offered at the parity boundary chains straight into SYNC.
              if (w_accept) begin
                w_state_nx  = ST_SYNC;
                w_shift_nx  = bus.data;
                w_parity_nx = ^{1'b1, bus.data};
              end else begin
                w_state_nx  = ST_END;
              end
            end
            ST_END:       w_state_nx = ST_IDLE;
            default:      w_state_nx = ST_IDLE;
          endcase
        end
      end
    end
  end

  assign w_level_nx = line_level(w_state_nx, w_cell_idx_nx, w_clk_cnt_nx,
                                 w_shift_nx[9], w_parity_nx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_clk_cnt    <= '0;
      r_cell_idx   <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_tx         <= 1'b0;
      r_tx_active  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_clk_cnt    <= w_clk_cnt_nx;
      r_cell_idx   <= w_cell_idx_nx;
      r_shift      <= w_shift_nx;
      r_parity     <= w_parity_nx;
      // Outputs are registered from next-state values so they line up with state.
      r_tx         <= w_level_nx;
      r_tx_active  <= (w_state_nx != ST_IDLE);
      r_frame_done <= (r_state == ST_END) && (w_state_nx == ST_IDLE);
    end
  end

  assign tx         = r_tx;
  assign tx_active  = r_tx_active;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
